// File: rtl/ecdsa_sig_s_n_if.sv
// ecdsa_sig_s_n_if: curve parameter type and signing-stage bus
//   params/kinv/inv_done/z/r/d : driven by the controller (master)
//   s/s_zero/Done              : driven by ecdsa_sig_s_n (slave)
package ecdsa_sig_s_n_pkg;
  typedef struct packed {
    logic [255:0] n;
  } curve_parameters_t;
endpackage

interface ecdsa_sig_s_n_if #(parameter int WIDTH = 256);
  import ecdsa_sig_s_n_pkg::*;
  curve_parameters_t params;
  logic [WIDTH-1:0] kinv, z, r, d, s;
  logic inv_done, s_zero, Done;
  modport master (output params, kinv, inv_done, z, r, d, input s, s_zero, Done);
  modport slave (input params, kinv, inv_done, z, r, d, output s, s_zero, Done);
endinterface

// File: rtl/ecdsa_sig_s_n.sv
// ecdsa_sig_s_n: s = kinv * (z + r*d) mod n via two bit-serial interleaved modular multiplies
//   clk   : system clock
//   Reset : synchronous active-high, returns to Init and clears outputs
//   bus   : slave side; inputs params.n/kinv/inv_done/z/r/d, outputs s/s_zero/Done
module ecdsa_sig_s_n #(
  parameter int WIDTH = 256
) (
  input logic clk,
  input logic Reset,
  ecdsa_sig_s_n_if.slave bus
);
  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {INIT, WAIT_INV, MUL_RD, ADD_Z, MUL_K, CHECK, FINISH} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] n, kinv_q, z_q, r_q, d_q, acc, t, addend, step, tz;
  logic [XW-1:0] n_x, dbl, dbl_r, sum, zr, tsum;
  logic [CW-1:0] cnt;
  logic mbit;
  assign n = bus.params.n[WIDTH-1:0];
  assign n_x = {2'b0, n};
  // One interleaved multiply step shared by both passes: acc = 2*acc (+ addend) mod n
  always_comb begin
    mbit = state == MUL_RD ? d_q[cnt] : t[cnt];
    addend = state == MUL_RD ? r_q : kinv_q;
    dbl = {1'b0, acc, 1'b0};
    dbl_r = dbl >= n_x ? dbl - n_x : dbl;
    sum = dbl_r + (mbit ? {2'b0, addend} : '0);
    step = WIDTH'(sum >= n_x ? sum - n_x : sum);
    zr = {2'b0, z_q} >= n_x ? {2'b0, z_q} - n_x : {2'b0, z_q};
    tsum = {2'b0, t} + zr;
    tz = WIDTH'(tsum >= n_x ? tsum - n_x : tsum);
  end
  always_ff @(posedge clk) state <= Reset ? INIT : state_n;
  always_comb begin
    state_n = state;
    case (state)
      INIT: state_n = WAIT_INV;
      WAIT_INV: state_n = bus.inv_done ? MUL_RD : WAIT_INV;
      MUL_RD: state_n = cnt == '0 ? ADD_Z : MUL_RD;
      ADD_Z: state_n = MUL_K;
      MUL_K: state_n = cnt == '0 ? CHECK : MUL_K;
      CHECK: state_n = FINISH;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      acc <= '0;
      t <= '0;
      cnt <= '0;
      kinv_q <= '0;
      z_q <= '0;
      r_q <= '0;
      d_q <= '0;
      bus.s <= '0;
      bus.s_zero <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          acc <= '0;
          t <= '0;
          cnt <= '0;
        end
        WAIT_INV: if (bus.inv_done) begin
          kinv_q <= bus.kinv;
          z_q <= bus.z;
          r_q <= bus.r;
          d_q <= bus.d;
          cnt <= CW'(WIDTH - 1);
        end
        MUL_RD: begin
          acc <= step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) t <= step;
        end
        ADD_Z: begin
          t <= tz;
          acc <= '0;
          cnt <= CW'(WIDTH - 1);
        end
        MUL_K: begin
          acc <= step;
          cnt <= cnt - 1'b1;
        end
        CHECK: begin
          bus.s <= acc;
          bus.s_zero <= acc == '0;
          bus.Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ecdsa_sig_s_n.sv
// tb_ecdsa_sig_s_n: scoreboard bench for ecdsa_sig_s_n
module tb_ecdsa_sig_s_n;
  localparam logic [255:0] N_K1 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [255:0] N_97 = 256'd97;
  typedef struct {
    logic [255:0] s;
    logic zero;
  } exp_t;
  exp_t exp_q[$];
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  ecdsa_sig_s_n_if #(.WIDTH(256)) bus ();
  ecdsa_sig_s_n #(.WIDTH(256)) dut (.clk(clk), .Reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic expect_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  function automatic logic [255:0] model(input logic [255:0] n, r, d, z, k);
    logic [511:0] nx, tt;
    nx = {256'b0, n};
    tt = ({256'b0, r} * {256'b0, d} + {256'b0, z}) % nx;
    return 256'(({256'b0, k} * tt) % nx);
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x = {x[223:0], 32'($urandom)};
    return x;
  endfunction
  function automatic logic [255:0] below(input logic [255:0] x, input logic [255:0] n);
    return x >= n ? x - n : x;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    bus.inv_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [255:0] n, r, d, z, k);
    exp_t e;
    bus.params.n = n;
    bus.r = r;
    bus.d = d;
    bus.z = z;
    bus.kinv = k;
    e.s = model(n, r, d, z, k);
    e.zero = e.s == '0;
    exp_q.push_back(e);
    bus.inv_done = 1'b1;
    @(posedge clk);
    #1;
    bus.inv_done = 1'b0;
    bus.r = rnd256();
    bus.d = rnd256();
    bus.z = rnd256();
    bus.kinv = rnd256();
  endtask
  task automatic finish(input string tag);
    exp_t e;
    int lat = 0;
    for (int i = 1; i <= 600 && !bus.Done; i++) begin
      @(posedge clk);
      #1 lat = i;
    end
    e = exp_q.pop_front();
    expect_eq({tag, "_lat"}, 256'(lat), 256'd514);
    expect_eq({tag, "_s"}, bus.s, e.s);
    expect_eq({tag, "_zero"}, 256'(bus.s_zero), 256'(e.zero));
    @(posedge clk);
    #1 expect_eq({tag, "_held"}, 256'(bus.Done), 256'd1);
  endtask
  initial begin
    logic [255:0] r, d, z, k;
    bus.params.n = N_97;
    bus.r = '0;
    bus.d = '0;
    bus.z = '0;
    bus.kinv = '0;
    do_reset();
    expect_eq("rst_s", bus.s, '0);
    expect_eq("rst_zero", 256'(bus.s_zero), '0);
    expect_eq("rst_done", 256'(bus.Done), '0);
    do_reset();
    start(N_97, 5, 7, 10, 3);
    expect_eq("c1_model", exp_q[0].s, 256'd38);
    finish("c1");
    do_reset();
    start(N_97, 5, 7, 100, 3);
    expect_eq("c2_model", exp_q[0].s, 256'd17);
    finish("c2");
    do_reset();
    start(N_97, 5, 0, 0, 3);
    finish("c3");
    do_reset();
    bus.params.n = N_97;
    bus.r = 11;
    bus.d = 13;
    bus.z = 17;
    bus.kinv = 19;
    repeat (50) @(posedge clk);
    #1 expect_eq("c4_idle_done", 256'(bus.Done), '0);
    start(N_97, 5, 7, 10, 3);
    finish("c4");
    do_reset();
    start(N_97, 5, 7, 10, 3);
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 expect_eq("c5_abort_done", 256'(bus.Done), '0);
    expect_eq("c5_abort_s", bus.s, '0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    @(posedge clk);
    #1;
    start(N_97, 5, 7, 10, 3);
    finish("c5");
    for (int i = 0; i < 100; i++) begin
      r = below(rnd256(), N_K1);
      d = below(rnd256(), N_K1);
      z = rnd256();
      k = below(rnd256(), N_K1);
      do_reset();
      start(N_K1, r, d, z, k);
      finish("k1");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
